param_loader: RTL

Front-end input stage for the egg-drop accelerator. It takes the raw 16-bit switch bank and three raw push-buttons and synchronises and debounces them. It latches the floor count and egg resistance into stable registers, then sequences the CPU core's reset so a run starts only after valid parameters are loaded. Its outputs feed the CPU wrapper's `init_floors_i`, `init_resistance_i` and `rst_i` inputs, replacing ad-hoc latching in the top level.

---
 rtl/param_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/param_loader.sv
// param_loader: synchronises/debounces the switch bank and buttons, latches the run
// parameters and sequences the CPU core reset. Optional macro: PARAM_LOADER_AUTOSTART_EN.
module param_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter logic [15:0] MAX_FLOORS      = 16'hFFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] in_data_i,
   input  logic        load_floors_btn_i,
   input  logic        load_resist_btn_i,
   input  logic        start_btn_i,
   output logic [15:0] init_floors_o,
   output logic [15:0] init_resistance_o,
   output logic        cpu_rst_o,
   output logic        params_ready_o,
   output logic        param_error_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PARTIAL = 2'd1,
      S_READY   = 2'd2,
      S_RUN     = 2'd3
   } state_e;

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef PARAM_LOADER_AUTOSTART_EN
   localparam int NB = 2;
   logic [NB-1:0] btn_raw;
   assign btn_raw = {load_resist_btn_i, load_floors_btn_i};
`else
   localparam int NB = 3;
   logic [NB-1:0] btn_raw;
   assign btn_raw = {start_btn_i, load_resist_btn_i, load_floors_btn_i};
`endif

   logic [NB-1:0] btn_s1_q, btn_s2_q;
   logic [15:0]   data_s1_q, data_s2_q;
   logic [NB-1:0] pulse;

   // NOTE: synchroniser flops are plain registers, so resetting them costs nothing and
   // keeps the first post-reset cycles deterministic; a RAM array would be left unreset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         btn_s1_q  <= '0;
         btn_s2_q  <= '0;
         data_s1_q <= '0;
         data_s2_q <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous value.
         btn_s1_q  <= btn_raw;
         btn_s2_q  <= btn_s1_q;
         data_s1_q <= in_data_i;
         data_s2_q <= data_s1_q;
      end
   end

   for (genvar i = 0; i < NB; i++) begin : g_deb
      logic [CW-1:0] cnt_q;
      logic          level_q, prev_q, pulse_q;

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            prev_q  <= level_q;
            pulse_q <= level_q & ~prev_q;
            if (btn_s2_q[i] == level_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               level_q <= btn_s2_q[i];
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end

      assign pulse[i] = pulse_q;
   end

   logic fl_p, rs_p, start_req;
   assign fl_p = pulse[0];
   assign rs_p = pulse[1];
`ifdef PARAM_LOADER_AUTOSTART_EN
   assign start_req = 1'b1;
`else
   assign start_req = pulse[2];
`endif

   state_e      state_q, state_d;
   logic [15:0] floors_q, floors_d, resist_q, resist_d;
   logic        fl_ok_q, fl_ok_d, rs_ok_q, rs_ok_d;
   logic        err_q, err_d, cpu_rst_q, ready_q;
   logic        floors_valid;

   assign floors_valid = (floors_q != 16'd0) && ({1'b0, floors_q} <= {1'b0, MAX_FLOORS});

   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d  = state_q;
      floors_d = floors_q;
      resist_d = resist_q;
      fl_ok_d  = fl_ok_q;
      rs_ok_d  = rs_ok_q;
      err_d    = err_q;
      if (fl_p || rs_p) begin
         if (fl_p) begin
            floors_d = data_s2_q;
            fl_ok_d  = 1'b1;
         end
         if (rs_p) begin
            resist_d = data_s2_q;
            rs_ok_d  = 1'b1;
         end
         err_d   = 1'b0;
         state_d = (fl_ok_d && rs_ok_d) ? S_READY : S_PARTIAL;
      end else if (state_q == S_READY && start_req) begin
         if (floors_valid) begin
            state_d = S_RUN;
            err_d   = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Status outputs are registered from the next state so they align with state_o.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         floors_q  <= '0;
         resist_q  <= '0;
         fl_ok_q   <= 1'b0;
         rs_ok_q   <= 1'b0;
         err_q     <= 1'b0;
         cpu_rst_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         floors_q  <= floors_d;
         resist_q  <= resist_d;
         fl_ok_q   <= fl_ok_d;
         rs_ok_q   <= rs_ok_d;
         err_q     <= err_d;
         cpu_rst_q <= (state_d != S_RUN);
         ready_q   <= (state_d == S_READY) || (state_d == S_RUN);
      end
   end

   assign init_floors_o     = floors_q;
   assign init_resistance_o = resist_q;
   assign cpu_rst_o         = cpu_rst_q;
   assign params_ready_o    = ready_q;
   assign param_error_o     = err_q;
   assign state_o           = state_q;

endmodule
